// File: rtl/picomem_wb_bridge.sv
//------------------------------------------------------------------------------
// picomem_wb_bridge
//   PicoMem slave that turns each access into one classic Wishbone single cycle.
//   Optional bus timeout enabled by defining WB_TIMEOUT_EN.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module picomem_wb_bridge #(
  parameter int          ADDR_W         = 28,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_s_valid,
  output logic              mem_s_ready,
  input  logic [31:0]       mem_s_addr,
  input  logic [31:0]       mem_s_wdata,
  input  logic [3:0]        mem_s_wstrb,
  output logic [31:0]       mem_s_rdata,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state, w_state_d;
  logic              r_cyc, w_cyc_d;
  logic              r_we, w_we_d;
  logic [ADDR_W-1:0] r_adr, w_adr_d;
  logic [31:0]       r_dat, w_dat_d;
  logic [3:0]        r_sel, w_sel_d;
  logic [31:0]       r_rdata, w_rdata_d;
  logic              r_ready, w_ready_d;
  logic              r_bus_err, w_bus_err_d;
  logic              w_finish;

  // Address bits outside the word-address window are decoded upstream.
  logic [31-ADDR_W:0] w_unused_addr;
  assign w_unused_addr = {mem_s_addr[31:ADDR_W+2], mem_s_addr[1:0]};

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt, w_cnt_d;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_cyc_d     = r_cyc;
    w_we_d      = r_we;
    w_adr_d     = r_adr;
    w_dat_d     = r_dat;
    w_sel_d     = r_sel;
    w_rdata_d   = r_rdata;
    w_ready_d   = 1'b0;
    w_bus_err_d = r_bus_err;
    w_finish    = 1'b0;
`ifdef WB_TIMEOUT_EN
    w_cnt_d     = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (mem_s_valid) begin
          w_cyc_d   = 1'b1;
          w_we_d    = |mem_s_wstrb;
          w_adr_d   = mem_s_addr[ADDR_W+1:2];
          w_dat_d   = mem_s_wdata;
          w_sel_d   = (|mem_s_wstrb) ? mem_s_wstrb : 4'hF;
          w_state_d = S_BUS;
`ifdef WB_TIMEOUT_EN
          w_cnt_d   = 16'd0;
`endif
        end
      end
      S_BUS: begin
        // Error termination wins over a simultaneous ack.
        if (wb_err_i) begin
          w_rdata_d   = ERR_DATA;
          w_bus_err_d = 1'b1;
          w_finish    = 1'b1;
        end else if (wb_ack_i) begin
          w_rdata_d   = r_we ? 32'h0 : wb_dat_i;
          w_finish    = 1'b1;
        end
`ifdef WB_TIMEOUT_EN
        else if (r_cnt == c_to_last) begin
          w_rdata_d   = ERR_DATA;
          w_bus_err_d = 1'b1;
          w_finish    = 1'b1;
        end else begin
          w_cnt_d     = r_cnt + 16'd1;
        end
`endif
        if (w_finish) begin
          w_cyc_d   = 1'b0;
          w_we_d    = 1'b0;
          w_sel_d   = 4'h0;
          w_ready_d = 1'b1;
          w_state_d = S_RESP;
        end
      end
      S_RESP:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= 32'h0;
      r_sel     <= 4'h0;
      r_rdata   <= 32'h0;
      r_ready   <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cyc     <= w_cyc_d;
      r_we      <= w_we_d;
      r_adr     <= w_adr_d;
      r_dat     <= w_dat_d;
      r_sel     <= w_sel_d;
      r_rdata   <= w_rdata_d;
      r_ready   <= w_ready_d;
      r_bus_err <= w_bus_err_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= 16'd0;
    else       r_cnt <= w_cnt_d;
  end
`endif

  assign mem_s_ready = r_ready;
  assign mem_s_rdata = r_rdata;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;
  assign wb_we_o     = r_we;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat;
  assign wb_sel_o    = r_sel;
  assign bus_err     = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_picomem_wb_bridge.sv
//------------------------------------------------------------------------------
// tb_picomem_wb_bridge
//   Table-driven bench with an rdata scoreboard for picomem_wb_bridge.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_picomem_wb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_s_valid;
  logic        mem_s_ready;
  logic [31:0] mem_s_addr;
  logic [31:0] mem_s_wdata;
  logic [3:0]  mem_s_wstrb;
  logic [31:0] mem_s_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [27:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        bus_err;

  picomem_wb_bridge dut (
    .clk(clk), .reset(reset),
    .mem_s_valid(mem_s_valid), .mem_s_ready(mem_s_ready),
    .mem_s_addr(mem_s_addr), .mem_s_wdata(mem_s_wdata),
    .mem_s_wstrb(mem_s_wstrb), .mem_s_rdata(mem_s_rdata),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [27:0] exp_adr;
    logic        exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
    logic        exp_berr;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] sb_q [$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits up to 'budget' cycles for ready, then checks the completion against the scoreboard.
  task automatic finish_access(input int cycles_so_far, input int budget,
                               input int exp_lat, input logic exp_berr);
    int          n;
    logic [31:0] exp_rd;
    n = 0;
    do begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      n++;
    end while (!mem_s_ready && n < budget);
    chk("ready", {31'h0, mem_s_ready}, 32'h1);
    chk("latency", cycles_so_far + n, exp_lat);
    chk("cyc_at_ready", {31'h0, wb_cyc_o | wb_stb_o}, 32'h0);
    chk("we_sel_at_ready", {27'h0, wb_we_o, wb_sel_o}, 32'h0);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'h1, 32'h0);
    end else begin
      exp_rd = sb_q.pop_front();
      chk("rdata", mem_s_rdata, exp_rd);
    end
    chk("bus_err", {31'h0, bus_err}, {31'h0, exp_berr});
    mem_s_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    mem_s_valid = 1'b1;
    mem_s_addr  = v.addr;
    mem_s_wdata = v.wdata;
    mem_s_wstrb = v.wstrb;
    sb_q.push_back(v.exp_rdata);
    @(negedge clk);
    chk("cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h3);
    chk("adr", {4'h0, wb_adr_o}, {4'h0, v.exp_adr});
    chk("we", {31'h0, wb_we_o}, {31'h0, v.exp_we});
    chk("sel", {28'h0, wb_sel_o}, {28'h0, v.exp_sel});
    if (v.exp_we) chk("dat_o", wb_dat_o, v.wdata);
    repeat (v.delay) @(negedge clk);
    wb_ack_i = v.ack;
    wb_err_i = v.err;
    wb_dat_i = v.dat;
    finish_access(1 + v.delay, 50, v.delay + 2, v.exp_berr);
  endtask

  initial begin
    int   n;
    logic seen;

    //          addr          wdata         wstrb  dly ack err dat           adr          we    sel    rdata         berr
    vecs[0] = '{32'hC000_0010, 32'h0,        4'h0, 2, 1'b1, 1'b0, 32'h1234_5678, 28'h000_0004, 1'b0, 4'hF, 32'h1234_5678, 1'b0};
    vecs[1] = '{32'hC000_0008, 32'h0000_AB00, 4'h2, 0, 1'b1, 1'b0, 32'hFFFF_FFFF, 28'h000_0002, 1'b1, 4'h2, 32'h0,         1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0,        4'h0, 1, 1'b1, 1'b0, 32'hA5A5_5A5A, 28'hFFF_FFFF, 1'b0, 4'hF, 32'hA5A5_5A5A, 1'b0};
    vecs[3] = '{32'hC000_0100, 32'hCAFE_F00D, 4'hF, 4, 1'b1, 1'b0, 32'h0,         28'h000_0040, 1'b1, 4'hF, 32'h0,         1'b0};
    vecs[4] = '{32'hC000_0020, 32'h0,        4'h0, 1, 1'b1, 1'b1, 32'h1111_1111, 28'h000_0008, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{32'hC000_0004, 32'h0,        4'h0, 0, 1'b1, 1'b0, 32'h0BAD_F00D, 28'h000_0001, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b1};
    vecs[6] = '{32'hC000_000C, 32'h5500_0000, 4'h8, 0, 1'b0, 1'b1, 32'h0,         28'h000_0003, 1'b1, 4'h8, 32'hDEAD_BEEF, 1'b1};

    reset       = 1'b1;
    mem_s_valid = 1'b0;
    mem_s_addr  = 32'h0;
    mem_s_wdata = 32'h0;
    mem_s_wstrb = 4'h0;
    wb_dat_i    = 32'h0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {26'h0, mem_s_ready, wb_cyc_o, wb_stb_o, wb_we_o, bus_err, 1'b0}, 32'h0);
    chk("rst_adr_sel", {wb_adr_o, wb_sel_o}, 32'h0);
    chk("rst_dat_o", wb_dat_o, 32'h0);
    chk("rst_rdata", mem_s_rdata, 32'h0);
    reset = 1'b0;

    // Stray responses while idle must be ignored.
    @(negedge clk);
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    chk("idle_ignore", {29'h0, mem_s_ready, wb_cyc_o, bus_err}, 32'h0);

    // Consecutive vectors are back-to-back: each valid arrives the cycle after ready.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset two cycles into BUS discards the transaction.
    @(negedge clk);
    mem_s_valid = 1'b1;
    mem_s_addr  = 32'hC000_0040;
    mem_s_wstrb = 4'h0;
    @(negedge clk);
    chk("rstbus_cyc", {31'h0, wb_cyc_o}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    mem_s_valid = 1'b0;
    chk("rstbus_cyc_stb", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
    chk("rstbus_berr", {31'h0, bus_err}, 32'h0);
    seen = mem_s_ready;
    repeat (5) begin
      @(negedge clk);
      seen = seen | mem_s_ready;
    end
    chk("rstbus_no_ready", {31'h0, seen}, 32'h0);
    run_vec('{32'hC000_0080, 32'h0, 4'h0, 1, 1'b1, 1'b0, 32'h7777_0001,
              28'h000_0020, 1'b0, 4'hF, 32'h7777_0001, 1'b0});

    // Slave that never answers.
    @(negedge clk);
    mem_s_valid = 1'b1;
    mem_s_addr  = 32'hC000_0200;
    mem_s_wstrb = 4'h0;
`ifdef WB_TIMEOUT_EN
    sb_q.push_back(32'hDEAD_BEEF);
    finish_access(0, 1000, 256, 1'b1);
`else
    seen = 1'b0;
    n    = 0;
    while (n < 1000) begin
      @(negedge clk);
      seen = seen | mem_s_ready;
      n++;
    end
    chk("hang_no_ready", {31'h0, seen}, 32'h0);
    chk("hang_cyc", {31'h0, wb_cyc_o}, 32'h1);
    chk("hang_berr", {31'h0, bus_err}, 32'h0);
    reset       = 1'b1;
    mem_s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("hang_recover", {31'h0, wb_cyc_o}, 32'h0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
